// File: rtl/gpr_file_pkg.sv
// Shared CPU defines for the general-purpose register file: register count,
// index width, data width and write-back select codes.
package gpr_file_pkg;

  localparam int GPR_NUM    = 32;
  localparam int GPR_IDX_W  = 5;
  localparam int GPR_DATA_W = 32;

  // Write-back mux select codes; i_wdata arrives already selected by one of these.
  typedef enum logic [1:0] {
    GPR_W_SEL_ALU = 2'd0,
    GPR_W_SEL_MEM = 2'd1,
    GPR_W_SEL_MUL = 2'd2,
    GPR_W_SEL_CP0 = 2'd3
  } gpr_w_sel_e;

  typedef logic [GPR_IDX_W-1:0] gpr_idx_t;

  // True when an enabled write targets the given read index.
  function automatic logic idx_hit(input gpr_idx_t waddr, input gpr_idx_t raddr, input logic we);
    return we && (waddr == raddr);
  endfunction

endpackage

// File: rtl/gpr_file_scoreboard.sv
// Pending-destination bitmap for long-latency ops and the read-port stall logic.
// Register 0 can never become pending, so it never stalls.
module gpr_scoreboard
  import gpr_file_pkg::*;
#(
  parameter int REG_NUM = GPR_NUM
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic [GPR_IDX_W-1:0] i_waddr,
  input  logic                 i_pend_set,
  input  logic [GPR_IDX_W-1:0] i_pend_addr,
  input  logic [GPR_IDX_W-1:0] i_raddr1,
  input  logic [GPR_IDX_W-1:0] i_raddr2,
  output logic                 o_stall1,
  output logic                 o_stall2,
  output logic [REG_NUM-1:0]   o_pend_mask
);

  logic [REG_NUM-1:0] pend_q;
  logic [REG_NUM-1:0] pend_d;

  // Next bitmap: write-back clears, then a new issue sets (a new op supersedes the old one).
  always_comb begin
    pend_d = pend_q;
    if (i_we) begin
      pend_d[i_waddr] = 1'b0;
    end
    if (i_pend_set) begin
      pend_d[i_pend_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Bitmap register; reset discards any in-flight pending ops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // A same-cycle write-back resolves the hazard through the bypass, so it suppresses the stall.
  always_comb begin
    o_stall1 = (i_raddr1 != '0) && pend_q[i_raddr1] && !idx_hit(i_waddr, i_raddr1, i_we);
    o_stall2 = (i_raddr2 != '0) && pend_q[i_raddr2] && !idx_hit(i_waddr, i_raddr2, i_we);
  end

  assign o_pend_mask = pend_q;

endmodule

// File: rtl/gpr_file.sv
// General-purpose register file: two combinational read ports with write-back
// bypass, one write port, and a pending-register scoreboard for stall generation.
module gpr_file
  import gpr_file_pkg::*;
#(
  parameter int REG_NUM = GPR_NUM,
  parameter int DATA_W  = GPR_DATA_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic [GPR_IDX_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [GPR_IDX_W-1:0] i_raddr1,
  input  logic [GPR_IDX_W-1:0] i_raddr2,
  output logic [DATA_W-1:0]    o_rdata1,
  output logic [DATA_W-1:0]    o_rdata2,
  input  logic                 i_pend_set,
  input  logic [GPR_IDX_W-1:0] i_pend_addr,
  output logic                 o_stall1,
  output logic                 o_stall2,
  output logic [REG_NUM-1:0]   o_pend_mask
);

  logic [DATA_W-1:0] regs [REG_NUM];

  // Register storage; x0 is never written so it stays at its reset value of 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  // Zero-latency reads: x0 reads 0, a same-cycle write to the read index is forwarded.
  always_comb begin
    o_rdata1 = '0;
    o_rdata2 = '0;
    if (i_raddr1 != '0) begin
      o_rdata1 = idx_hit(i_waddr, i_raddr1, i_we) ? i_wdata : regs[i_raddr1];
    end
    if (i_raddr2 != '0) begin
      o_rdata2 = idx_hit(i_waddr, i_raddr2, i_we) ? i_wdata : regs[i_raddr2];
    end
  end

  gpr_scoreboard #(
    .REG_NUM(REG_NUM)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_we       (i_we),
    .i_waddr    (i_waddr),
    .i_pend_set (i_pend_set),
    .i_pend_addr(i_pend_addr),
    .i_raddr1   (i_raddr1),
    .i_raddr2   (i_raddr2),
    .o_stall1   (o_stall1),
    .o_stall2   (o_stall2),
    .o_pend_mask(o_pend_mask)
  );

endmodule

// File: doc/gpr_file.md
GPR_FILE -- requirements
Module: gpr_file

Interface
REQ-001 SHALL have one clock, i_clk; reset i_rst SHALL be synchronous and active-high.
REQ-002 SHALL have parameter REG_NUM, default 32, meaning number of general-purpose registers.
REQ-003 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-004 SHALL provide ports as listed below:
- i_clk  input  1  rising-edge clock
- i_rst  input  1  synchronous active-high reset
- i_we  input  1  write enable from write-back stage
- i_waddr  input  5  write register index
- i_wdata  input  32  write data, already selected by write-back mux
- i_raddr1  input  5  read port 1 index
- i_raddr2  input  5  read port 2 index
- o_rdata1  output  32  read port 1 data
- o_rdata2  output  32  read port 2 data
- i_pend_set  input  1  long-latency op (MUL/MEM/CP0) issued; mark destination pending
- i_pend_addr  input  5  destination index for i_pend_set
- o_stall1  output  1  read port 1 targets a pending register
- o_stall2  output  1  read port 2 targets a pending register
- o_pend_mask  output  32  pending bitmap, for debug/trace

Function
REQ-005 SHALL write i_wdata into register i_waddr at the rising edge when i_we=1 and i_waddr!=0.
REQ-006 SHALL ignore writes to register 0; reads of register 0 SHALL always return 0.
REQ-007 SHALL make reads combinational, with zero-cycle latency from address to data.
REQ-008 SHALL bypass: when i_we=1, i_waddr=raddrN and raddrN!=0, o_rdataN SHALL equal i_wdata in the same cycle.
REQ-009 SHALL set pending bit i_pend_addr at the clock edge when i_pend_set=1 and i_pend_addr!=0.
REQ-010 SHALL clear pending bit i_waddr at the clock edge when i_we=1.
REQ-011 SHALL resolve set and clear of the same index in the same cycle as set wins, because the new op supersedes the old one.
REQ-012 SHALL allow set and clear of different indices in the same cycle to both take effect.
REQ-013 SHALL assert o_stallN when pending[raddrN]=1, raddrN!=0, and NOT (i_we=1 and i_waddr=raddrN).
REQ-014 SHALL never raise a stall for register 0, even if pending is requested for it.
REQ-015 SHALL leave pending state unchanged when i_pend_set is issued for an already-pending register; no counting, single bit.
REQ-016 SHALL let both read ports address the same register, each returning identical data and stall.
REQ-017 SHALL drive o_pend_mask from the registered pending bitmap, with bit 0 always 0.

Reset
REQ-018 SHALL clear all REG_NUM registers to 0 at the clock edge with i_rst=1.
REQ-019 SHALL clear all pending bits with i_rst=1, so that o_stall1=o_stall2=0 and o_pend_mask=0 after reset.
REQ-020 SHALL give i_rst priority over i_we and i_pend_set in the same cycle; neither write nor set takes effect.
REQ-021 SHALL discard an in-flight pending op when reset occurs mid-operation; its later write SHALL still be accepted as a normal write.

Structure
REQ-022 SHALL take register count, index width and GPR_W_SEL codes from the shared CPU defines package, not local literals.
REQ-023 SHALL place the pending bitmap and stall logic in one sub-module, gpr_scoreboard; storage and bypass SHALL stay in gpr_file.

Verification
REQ-024 SHALL cover write then read: write x5=0x1234_5678, read x5 next cycle -> o_rdata1=0x1234_5678, stall 0.
REQ-025 SHALL cover bypass: i_we=1, waddr=7, wdata=0xDEAD_BEEF, raddr2=7 same cycle -> o_rdata2=0xDEAD_BEEF.
REQ-026 SHALL cover r0: write x0=0xFFFF_FFFF, and pend_set on x0 -> read x0 = 0, o_stall1=0, o_pend_mask[0]=0.
REQ-027 SHALL cover the scoreboard: pend_set x9; next cycle raddr1=9 -> o_stall1=1; write x9=0x42 -> same cycle o_stall1=0, o_rdata1=0x42; next cycle o_pend_mask[9]=0.
REQ-028 SHALL cover set/clear collision: x3 pending; same cycle i_we x3 and pend_set x3 -> o_pend_mask[3]=1 next cycle.
REQ-029 SHALL cover reset mid-op: x4=0x55 and x4 pending, assert i_rst one cycle -> x4 reads 0, o_pend_mask=0, stalls 0.
